// File: rtl/ahb_pkg.sv
// ahb_pkg
//   Shared AHB-Lite encodings for the memory responder and its RAM:
//   transfer types, HSIZE codes, HRESP codes, the responder state enum
//   and a helper that turns (size, address offset) into byte-lane enables.
//   No ports; imported by the responder top and the byte RAM.

package ahb_pkg;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'd0,
      HT_BUSY   = 2'd1,
      HT_NONSEQ = 2'd2,
      HT_SEQ    = 2'd3
   } htrans_e;

   localparam logic [2:0] HS_BYTE = 3'd0;
   localparam logic [2:0] HS_HALF = 3'd1;
   localparam logic [2:0] HS_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } slave_state_e;

   // Little-endian byte lanes touched by a transfer. Halfwords ignore
   // offset bit 0 so a misaligned half is aligned down when allowed.
   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offs);
      logic [3:0] mask;
      case (size)
         HS_BYTE: mask = 4'b0001 << offs;
         HS_HALF: mask = offs[1] ? 4'b1100 : 4'b0011;
         default: mask = 4'b1111;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/ahb_byte_ram.sv
// ahb_byte_ram
//   DEPTH x 32-bit word memory with four byte-write enables, synchronous
//   write and asynchronous (combinational) read on a shared address.
//   Contents are never reset.
// Ports:
//   clk    in   write clock (rising edge)
//   we     in   [3:0] per-byte write enables, bit i writes bits 8i+7:8i
//   addr   in   [AW-1:0] word address for both read and write
//   wdata  in   [31:0] write data
//   rdata  out  [31:0] read data, follows addr combinationally

module ahb_byte_ram
   import ahb_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_slave_mem.sv
// ahb_lite_slave_mem
//   AHB-Lite responder backed by a word-organised byte-writable memory.
//   Supports byte/half/word transfers, WAIT_STATES low cycles on every
//   OKAY data phase, and a two-cycle ERROR response for out-of-range,
//   bad-size or (optionally) misaligned transfers.
// Parameters:
//   DEPTH            number of 32-bit words (byte space 0 .. DEPTH*4-1)
//   WAIT_STATES      HREADYOUT-low cycles per OKAY data phase (0..15)
//   ERR_ON_MISALIGN  1: misaligned half/word -> ERROR, 0: aligned down
// Ports:
//   HCLK       in   bus clock, rising edge
//   HRESET     in   synchronous active-high reset
//   HSEL       in   select from decoder
//   HADDR      in   [31:0] address-phase byte address
//   HWRITE     in   1 = write
//   HSIZE      in   [2:0] 0 byte, 1 half, 2 word, >2 error
//   HBURST     in   [2:0] unused
//   HPROT      in   [3:0] unused
//   HTRANS     in   [1:0] IDLE/BUSY/NONSEQ/SEQ
//   HMASTLOCK  in   unused
//   HREADY     in   bus-wide ready from the mux
//   HWDATA     in   [31:0] write data (data phase)
//   HREADYOUT  out  responder ready
//   HRESP      out  0 OKAY, 1 ERROR
//   HRDATA     out  [31:0] read data (data phase), else 0

module ahb_lite_slave_mem
   import ahb_pkg::*;
#(
   parameter int unsigned DEPTH           = 256,
   parameter int unsigned WAIT_STATES     = 0,
   parameter bit          ERR_ON_MISALIGN = 1'b1
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic [1:0]  HTRANS,
   input  logic        HMASTLOCK,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);
   localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_STATES);

   slave_state_e  state_q;
   logic [3:0]    wait_cnt_q;
   logic          dphase_q;      // OKAY data phase outstanding (waiting or completing)
   logic [AW+1:0] addr_q;
   logic          write_q;
   logic [2:0]    size_q;
   logic          hreadyout_q;
   logic          hresp_q;

   htrans_e       trans;
   logic          can_accept;
   logic          accept;
   logic          misalign;
   logic          req_err;
   logic          complete;
   logic          commit;
   logic [3:0]    byte_we;
   logic [31:0]   ram_rdata;

   logic          unused_inputs;
   assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK};

   assign trans = htrans_e'(HTRANS);

   // Only idle or final-error cycles have HREADYOUT high, so only they can
   // take a new address phase; anything presented earlier is held by the master.
   assign can_accept = (state_q == ST_IDLE) || (state_q == ST_ERR2);
   assign accept     = can_accept && HSEL && HREADY &&
                       ((trans == HT_NONSEQ) || (trans == HT_SEQ));

   assign misalign = ((HSIZE == HS_HALF) && HADDR[0]) ||
                     ((HSIZE == HS_WORD) && (HADDR[1:0] != 2'b00));
   assign req_err  = (HADDR >= ADDR_LIMIT) || (HSIZE > HS_WORD) ||
                     (ERR_ON_MISALIGN && misalign);

   // The data phase finishes on the edge where the FSM sits in ST_IDLE with
   // a pending transfer: immediately for zero waits, after ST_WAIT otherwise.
   assign complete = (state_q == ST_IDLE) && dphase_q;
   assign commit   = complete && write_q && !HRESET;
   assign byte_we  = commit ? lane_mask(size_q, addr_q[1:0]) : 4'b0000;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= 4'd0;
         dphase_q    <= 1'b0;
         addr_q      <= '0;
         write_q     <= 1'b0;
         size_q      <= HS_BYTE;
         hreadyout_q <= 1'b1;
         hresp_q     <= HRESP_OKAY;
      end else begin
         case (state_q)
            ST_IDLE, ST_ERR2: begin
               if (accept) begin
                  addr_q  <= HADDR[AW+1:0];
                  write_q <= HWRITE;
                  size_q  <= HSIZE;
                  if (req_err) begin
                     state_q     <= ST_ERR1;
                     dphase_q    <= 1'b0;
                     hreadyout_q <= 1'b0;
                     hresp_q     <= HRESP_ERROR;
                  end else if (WAIT_STATES != 0) begin
                     state_q     <= ST_WAIT;
                     wait_cnt_q  <= WAIT_INIT;
                     dphase_q    <= 1'b1;
                     hreadyout_q <= 1'b0;
                     hresp_q     <= HRESP_OKAY;
                  end else begin
                     state_q     <= ST_IDLE;
                     dphase_q    <= 1'b1;
                     hreadyout_q <= 1'b1;
                     hresp_q     <= HRESP_OKAY;
                  end
               end else begin
                  state_q     <= ST_IDLE;
                  dphase_q    <= 1'b0;
                  hreadyout_q <= 1'b1;
                  hresp_q     <= HRESP_OKAY;
               end
            end
            ST_WAIT: begin
               wait_cnt_q <= wait_cnt_q - 4'd1;
               if (wait_cnt_q == 4'd1) begin
                  // Next cycle is the completing data-phase cycle.
                  state_q     <= ST_IDLE;
                  hreadyout_q <= 1'b1;
               end
            end
            ST_ERR1: begin
               state_q     <= ST_ERR2;
               hreadyout_q <= 1'b1;
               hresp_q     <= HRESP_ERROR;
            end
            default: begin
               state_q     <= ST_IDLE;
               dphase_q    <= 1'b0;
               hreadyout_q <= 1'b1;
               hresp_q     <= HRESP_OKAY;
            end
         endcase
      end
   end

   ahb_byte_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (HCLK),
      .we    (byte_we),
      .addr  (addr_q[AW+1:2]),
      .wdata (HWDATA),
      .rdata (ram_rdata)
   );

   assign HREADYOUT = hreadyout_q;
   assign HRESP     = hresp_q;
   assign HRDATA    = (dphase_q && !write_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
module tb_ahb_lite_slave_mem;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        hsel0, hsel3;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   logic [31:0] hwdata;
   logic [2:0]  hburst = 3'd0;
   logic [3:0]  hprot = 4'b0011;
   logic        hlock = 1'b0;
   logic        ro0, ro3, rs0, rs3;
   logic [31:0] rd0, rd3;

   int checks = 0;
   int failures = 0;

   // Expected memory image per DUT: index 0 -> zero-wait DUT, 1 -> 3-wait DUT.
   logic [31:0] model [2][256];

   always #5 HCLK = ~HCLK;

   ahb_lite_slave_mem #(.DEPTH(256), .WAIT_STATES(0), .ERR_ON_MISALIGN(1'b1)) u_dut0 (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
      .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hlock),
      .HREADY(ro0), .HWDATA(hwdata), .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0)
   );

   ahb_lite_slave_mem #(.DEPTH(256), .WAIT_STATES(3), .ERR_ON_MISALIGN(1'b1)) u_dut3 (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel3), .HADDR(haddr), .HWRITE(hwrite),
      .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hlock),
      .HREADY(ro3), .HWDATA(hwdata), .HREADYOUT(ro3), .HRESP(rs3), .HRDATA(rd3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic rdy(input int d);
      return (d == 0) ? ro0 : ro3;
   endfunction

   function automatic logic rsp(input int d);
      return (d == 0) ? rs0 : rs3;
   endfunction

   function automatic logic [31:0] rdat(input int d);
      return (d == 0) ? rd0 : rd3;
   endfunction

   // Transfer outcome from the protocol rules: outside memory, bad size, or
   // not a multiple of the access size -> ERROR.
   function automatic bit exp_err(input logic [2:0] sz, input logic [31:0] a);
      int unsigned n;
      if (a >= 32'd1024 || sz > 3'd2) return 1'b1;
      n = 1 << sz;
      return (a % n) != 0;
   endfunction

   task automatic model_write(input int d, input logic [2:0] sz, input logic [31:0] a,
                              input logic [31:0] wd);
      int unsigned n, base, lane;
      n    = 1 << sz;
      base = a - (a % n);
      for (int unsigned b = 0; b < n; b++) begin
         lane = (base + b) % 4;
         model[d][a[9:2]][8*lane +: 8] = wd[8*lane +: 8];
      end
   endtask

   // Single non-pipelined transfer; called and returns at a negedge.
   task automatic xfer(input int d, input bit wr, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic rlow,
                       output logic rdone, output int waits);
      if (d == 0) hsel0 = 1'b1; else hsel3 = 1'b1;
      haddr  = a;
      hwrite = wr;
      hsize  = sz;
      htrans = 2'd2;
      @(negedge HCLK);
      hsel0  = 1'b0;
      hsel3  = 1'b0;
      htrans = 2'd0;
      hwdata = wd;
      waits  = 0;
      rlow   = 1'b0;
      while (!rdy(d) && waits < 40) begin
         rlow = rlow | rsp(d);
         waits++;
         @(negedge HCLK);
      end
      if (waits >= 40) chk("xfer_timeout", 32'(waits), 32'd0);
      rdone = rsp(d);
      rd    = rdat(d);
      @(negedge HCLK);
   endtask

   task automatic op(input int d, input bit wr, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input string tag);
      logic [31:0] rd, erd;
      logic        rlow, rdone;
      int          w;
      bit          ee;
      ee  = exp_err(sz, a);
      erd = 32'h0;
      if (!ee && !wr) erd = model[d][a[9:2]];
      xfer(d, wr, sz, a, wd, rd, rlow, rdone, w);
      chk({tag, "_waits"}, 32'(w), ee ? 32'd1 : ((d == 0) ? 32'd0 : 32'd3));
      chk({tag, "_resp_low"}, {31'd0, rlow}, {31'd0, ee});
      chk({tag, "_resp"}, {31'd0, rdone}, {31'd0, ee});
      chk({tag, "_rdata"}, rd, erd);
      if (!ee && wr) model_write(d, sz, a, wd);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lows;
      logic [2:0]  sz;
      logic [31:0] a;

      // Reset with a selected NONSEQ held on the bus.
      HRESET = 1'b1; hsel0 = 1'b1; hsel3 = 1'b1; htrans = 2'd2;
      haddr = 32'h0; hwrite = 1'b0; hsize = 3'd2; hwdata = 32'h0;
      for (int k = 0; k < 2; k++) begin
         @(negedge HCLK);
         chk("rst_ready0", {31'd0, ro0}, 32'd1); chk("rst_resp0", {31'd0, rs0}, 32'd0);
         chk("rst_rdata0", rd0, 32'd0);
         chk("rst_ready3", {31'd0, ro3}, 32'd1); chk("rst_resp3", {31'd0, rs3}, 32'd0);
         chk("rst_rdata3", rd3, 32'd0);
      end
      HRESET = 1'b0; hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'd0;
      @(negedge HCLK);
      chk("post_rst_ready0", {31'd0, ro0}, 32'd1); chk("post_rst_rdata0", rd0, 32'd0);
      chk("post_rst_ready3", {31'd0, ro3}, 32'd1); chk("post_rst_resp3", {31'd0, rs3}, 32'd0);

      // Known contents for the low 32 words of both memories.
      for (int i = 0; i < 32; i++) begin
         op(0, 1'b1, 3'd2, 32'(i * 4), $urandom, "init0");
         op(1, 1'b1, 3'd2, 32'(i * 4), $urandom, "init3");
      end

      // Zero-wait back-to-back write then read of the same word.
      hsel0 = 1'b1; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; htrans = 2'd2;
      @(negedge HCLK);
      chk("b2b_wr_ready", {31'd0, ro0}, 32'd1);
      hwdata = 32'hDEADBEEF; hwrite = 1'b0;
      @(negedge HCLK);
      chk("b2b_rd_ready", {31'd0, ro0}, 32'd1);
      chk("b2b_rd_data", rd0, 32'hDEADBEEF);
      hsel0 = 1'b0; htrans = 2'd0;
      @(negedge HCLK);
      chk("b2b_idle_ready", {31'd0, ro0}, 32'd1);
      model[0][4] = 32'hDEADBEEF;

      // Byte and halfword lane writes (other lanes carry junk).
      op(0, 1'b1, 3'd2, 32'h10, 32'h11223344, "lane_w");
      op(0, 1'b1, 3'd0, 32'h13, 32'hAA5A5A5A, "lane_b");
      chk("lane_model_b", model[0][4], 32'hAA223344);
      op(0, 1'b0, 3'd2, 32'h10, 32'h0, "lane_rb");
      op(0, 1'b1, 3'd1, 32'h12, 32'h5566C3C3, "lane_h");
      chk("lane_model_h", model[0][4], 32'h55663344);
      op(0, 1'b0, 3'd2, 32'h10, 32'h0, "lane_rh");

      // Three wait states with a second NONSEQ held during the waits.
      hsel3 = 1'b1; haddr = 32'h08; hwrite = 1'b0; hsize = 3'd2; htrans = 2'd2;
      @(negedge HCLK);
      haddr = 32'h0C;
      lows = 0;
      while (!ro3 && lows < 20) begin lows++; @(negedge HCLK); end
      chk("ws3_lows1", 32'(lows), 32'd3);
      chk("ws3_data1", rd3, model[1][2]);
      @(negedge HCLK);
      hsel3 = 1'b0; htrans = 2'd0;
      lows = 0;
      while (!ro3 && lows < 20) begin lows++; @(negedge HCLK); end
      chk("ws3_lows2", 32'(lows), 32'd3);
      chk("ws3_data2", rd3, model[1][3]);
      @(negedge HCLK);

      // Error responses leave memory untouched.
      op(0, 1'b0, 3'd2, 32'h400, 32'h0, "err_oor");
      op(0, 1'b1, 3'd2, 32'h02, 32'hFFFFFFFF, "err_mis");
      op(0, 1'b1, 3'd3, 32'h00, 32'hFFFFFFFF, "err_size");
      op(0, 1'b0, 3'd2, 32'h00, 32'h0, "err_unchanged");
      op(1, 1'b1, 3'd1, 32'h21, 32'hFFFFFFFF, "err_half3");
      op(1, 1'b0, 3'd2, 32'h20, 32'h0, "err_unchanged3");

      // Reset during the wait states of a write abandons it.
      hsel3 = 1'b1; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2; htrans = 2'd2;
      @(negedge HCLK);
      hsel3 = 1'b0; htrans = 2'd0; hwdata = 32'hCAFEF00D;
      chk("rstw_waiting", {31'd0, ro3}, 32'd0);
      HRESET = 1'b1;
      @(negedge HCLK);
      HRESET = 1'b0;
      chk("rstw_ready", {31'd0, ro3}, 32'd1);
      chk("rstw_resp", {31'd0, rs3}, 32'd0);
      op(1, 1'b0, 3'd2, 32'h20, 32'h0, "rstw_old");

      // Randomized transfers against the model.
      for (int i = 0; i < 240; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: sz = 3'd0;
            3, 4, 5: sz = 3'd1;
            6, 7, 8: sz = 3'd2;
            default: sz = 3'($urandom_range(3, 7));
         endcase
         if ($urandom_range(0, 9) == 0) a = 32'h400 + 32'($urandom_range(0, 4095));
         else a = 32'($urandom_range(0, 127));
         op(i % 2, 1'($urandom_range(0, 1)), sz, a, $urandom, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ahb_lite_slave_mem.md
Name: ahb_lite_slave_mem

Overview:
AHB-Lite responder (slave) that sits opposite the team's AHB-Lite master on the same bus, behind the decoder and mux.
Provides a word-organised SRAM-style register space with byte-lane writes, programmable wait states and a two-cycle ERROR response.
Used as the default memory target for master bring-up and as the template for peripheral slaves (e.g. a UART register bank).

Parameters:
DEPTH, 256, number of 32-bit words; byte address space is 0 .. DEPTH*4-1 (offset from HADDR bit 0).
WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase (0..15).
ERR_ON_MISALIGN, 1, 1 = misaligned HADDR/HSIZE combinations get an ERROR response; 0 = silently aligned down.

Ports:
HCLK  in  1  bus clock; all logic on rising edge
HRESET  in  1  synchronous, active-high reset
HSEL  in  1  slave select from decoder
HADDR  in  32  address-phase address
HWRITE  in  1  1 = write
HSIZE  in  3  0 = byte, 1 = half, 2 = word; >2 is an error
HBURST  in  3  accepted, not used for decode (SINGLE/INCR only)
HPROT  in  4  ignored
HTRANS  in  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ
HMASTLOCK  in  1  ignored
HREADY  in  1  bus-wide ready (mux output)
HWDATA  in  32  write data, valid in data phase
HREADYOUT  out  1  slave ready
HRESP  out  1  0 = OKAY, 1 = ERROR
HRDATA  out  32  read data

Behaviour:
- Reset (HRESET=1 at a clock edge): HREADYOUT=1, HRESP=0, HRDATA=0, FSM to ST_IDLE, wait counter 0, all address-phase registers cleared.
  - Memory contents are not reset.
  - A reset during a wait or ERROR sequence abandons that transfer; no write commits.
- Accept: transfer accepted when HSEL & HREADY & HTRANS[1] at a rising edge.
  - Register HADDR, HWRITE, HSIZE; the data phase starts next cycle.
  - IDLE/BUSY or unselected cycles: no data phase; slave stays or returns to OKAY with HREADYOUT=1.
- Error check at accept:
  - addr >= DEPTH*4, or HSIZE>2, or (ERR_ON_MISALIGN and HSIZE=1 and HADDR[0]) or (HSIZE=2 and HADDR[1:0]!=0) -> error transfer.
- FSM states: ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2.
  - ST_IDLE: HREADYOUT=1, HRESP=0.
    - OKAY accept with WAIT_STATES>0 -> ST_WAIT, counter=WAIT_STATES.
    - OKAY accept with WAIT_STATES=0 -> stay; zero-wait data phase next cycle.
    - Error accept -> ST_ERR1.
  - ST_WAIT: HREADYOUT=0, HRESP=0, counter decrements.
    - Counter==1 -> go to the completing data-phase cycle: HREADYOUT=1, then re-evaluate accept (back-to-back pipelining allowed).
  - ST_ERR1: HREADYOUT=0, HRESP=1 -> ST_ERR2.
  - ST_ERR2: HREADYOUT=1, HRESP=1; accepts a new transfer like ST_IDLE (the master may cancel with IDLE).
  - Error transfers never write memory; HRDATA=0.
- Data phase completion (HREADYOUT=1, OKAY):
  - Write: commit HWDATA lanes at that edge. Little-endian lanes:
    - byte -> lane HADDR[1:0]
    - half -> lanes {HADDR[1],0}..+1
    - word -> all lanes.
  - Read: HRDATA = mem[addr_q[..:2]] combinationally during the read data phase, else 0. Full word returned; the master selects lanes.
  - Read-after-write to the same address in consecutive transfers returns the new data (the write commits before the read data phase).
- New address phases during HREADYOUT=0 are ignored (HREADY low); the master holds them.

Decomposition:
- Package ahb_pkg:
  - htrans_e {HT_IDLE, HT_BUSY, HT_NONSEQ, HT_SEQ}
  - hsize constants HS_BYTE/HS_HALF/HS_WORD
  - HRESP_OKAY/HRESP_ERROR
  - slave state enum
- One sub-module: ahb_byte_ram (DEPTH x 32, 4 byte-write-enables, async read, sync write).

Test Plan:
- Reset with HSEL=1, HTRANS=NONSEQ held -> HREADYOUT=1, HRESP=0, HRDATA=0 during and one cycle after reset.
- WAIT_STATES=0: write word 0xDEADBEEF @0x10, then read @0x10 back-to-back -> HREADYOUT never low; HRDATA=0xDEADBEEF in read data phase.
- Byte write 0xAA @0x13 over 0x11223344 @0x10 -> read returns 0xAA223344; half write 0x5566 @0x12 -> 0x55663344.
- WAIT_STATES=3: single read -> exactly 3 cycles HREADYOUT=0, data valid on the 4th data-phase cycle; a pipelined NONSEQ held by the master is accepted only then.
- Read @DEPTH*4 (0x400), and word access @0x02 -> cycle 1 HREADYOUT=0/HRESP=1, cycle 2 HREADYOUT=1/HRESP=1, memory unchanged.
- HRESET asserted in ST_WAIT of a write @0x20 -> next cycle ST_IDLE with HREADYOUT=1; read @0x20 returns the old contents.
